// File: rtl/instr_feeder_pkg.sv
// Shared definitions for the instruction feeder.
// Holds the opcode constants, the FSM state encoding, the default
// watchdog limit, and a helper that extracts the opcode field from a word.
package instr_feeder_pkg;

  localparam logic [2:0] OP_MVI      = 3'b001;
  localparam logic [2:0] OP_HALT     = 3'b111;
  localparam int         TMO_CYC_DEF = 15;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LATCH  = 3'd2,
    S_ISSUE  = 3'd3,
    S_WAIT   = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  // Instruction word layout: opcode=[8:6], Y=[5:3], X=[2:0]
  function automatic logic [2:0] opcode_of(input logic [15:0] w);
    return w[8:6];
  endfunction

endpackage

// File: rtl/instr_feeder_wdog.sv
// Watchdog counter for the WAIT state.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   clr      : synchronous clear (held while the FSM is not waiting)
//   en       : count one cycle
//   tc       : terminal count, high during the TC-th enabled cycle
// The count saturates at TC-1, so tc stays high until cleared.
module wdog_count #(
  parameter int TC = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = (TC < 2) ? 1 : $clog2(TC);

  logic [W-1:0] cnt;

  assign tc = (cnt == W'(TC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/instr_feeder.sv
// Instruction feeder: walks a registered program ROM and hands one
// instruction at a time to a processor, waiting for its Done flag.
// Ports:
//   Clock, Reset  : clock, asynchronous active-high reset
//   Start         : begin execution at address 0 (ignored while Busy)
//   MemAddr/MemData : ROM address out, ROM data in (one-cycle latency)
//   DIN, Run      : instruction/immediate word and one-cycle issue strobe
//   Done          : processor completion flag, sampled only in WAIT
//   Busy, PC, InstrCount, Timeout : status outputs
// mvi instructions carry an immediate in the following ROM word; it is
// requested during ISSUE so that it arrives in the first WAIT cycle.
module instr_feeder
  import instr_feeder_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [15:0]       MemData,
  output logic [15:0]       DIN,
  output logic              Run,
  input  logic              Done,
  output logic              Busy,
  output logic [ADDR_W-1:0] PC,
  output logic [7:0]        InstrCount,
  output logic              Timeout
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_inc1;
  logic [ADDR_W-1:0] pc_inc2;
  logic [7:0]        icnt_r;
  logic              tmo_r;
  logic              first_wait;
  logic [15:0]       instr_p0;
  logic [15:0]       imm_p0;
  logic              is_mvi;
  logic              wd_en;
  logic              wd_clr;
  logic              wd_tc;

  assign pc_inc1    = pc_r + ADDR_W'(1);
  assign pc_inc2    = pc_r + ADDR_W'(2);
  assign is_mvi     = (opcode_of(instr_p0) == OP_MVI);
  assign PC         = pc_r;
  assign InstrCount = icnt_r;
  assign Timeout    = tmo_r;
  assign wd_clr     = (state != S_WAIT);

  wdog_count #(
    .TC (TMO_CYC)
  ) u_wdog (
    .clk (Clock),
    .rst (Reset),
    .clr (wd_clr),
    .en  (wd_en),
    .tc  (wd_tc)
  );

  // Next state and combinational outputs
  always_comb begin
    state_nxt = state;
    MemAddr   = '0;
    DIN       = '0;
    Run       = 1'b0;
    Busy      = 1'b1;
    wd_en     = 1'b0;
    case (state)
      S_IDLE, S_HALTED: begin
        Busy = 1'b0;
        if (Start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        MemAddr   = pc_r;
        state_nxt = S_LATCH;
      end
      S_LATCH: begin
        MemAddr   = pc_r;
        state_nxt = (opcode_of(MemData) == OP_HALT) ? S_HALTED : S_ISSUE;
      end
      S_ISSUE: begin
        MemAddr   = pc_inc1;
        DIN       = instr_p0;
        Run       = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        MemAddr = pc_inc1;
        wd_en   = 1'b1;
        // The immediate is live on MemData only in the first WAIT cycle
        if (is_mvi) DIN = first_wait ? MemData : imm_p0;
        else        DIN = instr_p0;
        if (Done)       state_nxt = S_FETCH;
        else if (wd_tc) state_nxt = S_HALTED;
      end
      default: begin
        Busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Control state
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= S_IDLE;
      pc_r       <= '0;
      icnt_r     <= '0;
      tmo_r      <= 1'b0;
      first_wait <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE, S_HALTED: begin
          if (Start) begin
            pc_r   <= '0;
            icnt_r <= '0;
            tmo_r  <= 1'b0;
          end
        end
        S_ISSUE: first_wait <= 1'b1;
        S_WAIT: begin
          first_wait <= 1'b0;
          if (Done) begin
            pc_r   <= is_mvi ? pc_inc2 : pc_inc1;
            icnt_r <= icnt_r + 8'd1;
          end else if (wd_tc) begin
            tmo_r <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Instruction / immediate capture
  always_ff @(posedge Clock) begin
    if (state == S_LATCH)              instr_p0 <= MemData;
    if (state == S_WAIT && first_wait) imm_p0   <= MemData;
  end

endmodule

// File: tb/tb_instr_feeder.sv
// Directed bench for instr_feeder: a registered ROM model feeds the DUT,
// and expected values are hand-derived cycle by cycle.
module tb_instr_feeder;

  logic        Clock = 1'b0;
  logic        Reset, Start, Done;
  logic [4:0]  MemAddr, PC;
  logic [15:0] MemData = '0;
  logic [15:0] DIN;
  logic        Run, Busy, Timeout;
  logic [7:0]  InstrCount;

  logic        Reset2, Start2, Done2;
  logic [1:0]  MemAddr2, PC2;
  logic [15:0] MemData2 = '0;
  logic [15:0] DIN2;
  logic        Run2, Busy2, Timeout2;
  logic [7:0]  InstrCount2;

  logic [15:0] rom  [32];
  logic [15:0] rom2 [4];

  int checks   = 0;
  int failures = 0;
  int run_cnt  = 0;
  int run2_cnt = 0;
  int base;

  always #5 Clock = ~Clock;

  instr_feeder #(.ADDR_W(5), .TMO_CYC(15)) u_dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .MemAddr(MemAddr),
    .MemData(MemData), .DIN(DIN), .Run(Run), .Done(Done), .Busy(Busy),
    .PC(PC), .InstrCount(InstrCount), .Timeout(Timeout)
  );

  instr_feeder #(.ADDR_W(2), .TMO_CYC(15)) u_dut2 (
    .Clock(Clock), .Reset(Reset2), .Start(Start2), .MemAddr(MemAddr2),
    .MemData(MemData2), .DIN(DIN2), .Run(Run2), .Done(Done2), .Busy(Busy2),
    .PC(PC2), .InstrCount(InstrCount2), .Timeout(Timeout2)
  );

  always @(posedge Clock) begin
    MemData  <= rom[MemAddr];
    MemData2 <= rom2[MemAddr2];
    if (Run === 1'b1)  run_cnt  <= run_cnt + 1;
    if (Run2 === 1'b1) run2_cnt <= run2_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clock);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    Reset = 1'b1; Reset2 = 1'b1;
    Start = 1'b0; Done = 1'b0; Start2 = 1'b0; Done2 = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = 16'h01C0;
    rom2[0] = 16'h0080; rom2[1] = 16'h0080; rom2[2] = 16'h0080; rom2[3] = 16'h0042;
    tick(); tick();

    // Reset state
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_run", 32'(Run), 0);
    chk("rst_pc", 32'(PC), 0);
    chk("rst_memaddr", 32'(MemAddr), 0);
    chk("rst_din", 32'(DIN), 0);
    chk("rst_icnt", 32'(InstrCount), 0);
    chk("rst_tmo", 32'(Timeout), 0);
    Reset = 1'b0;
    tick(); tick(); tick();
    chk("no_run_without_start", 32'(run_cnt), 0);
    chk("idle_busy", 32'(Busy), 0);

    // Single mv then HALT, Done two cycles after Run
    rom[0] = 16'h0008; rom[1] = 16'h01C0; base = run_cnt;
    Start = 1'b1; tick(); Start = 1'b0;
    chk("t1_fetch_busy", 32'(Busy), 1);
    chk("t1_fetch_memaddr", 32'(MemAddr), 0);
    chk("t1_fetch_run", 32'(Run), 0);
    tick();
    chk("t1_latch_run", 32'(Run), 0);
    tick();
    chk("t1_issue_run", 32'(Run), 1);
    chk("t1_issue_din", 32'(DIN), 'h0008);
    chk("t1_issue_memaddr", 32'(MemAddr), 1);
    tick();
    chk("t1_wait_run", 32'(Run), 0);
    chk("t1_wait_din", 32'(DIN), 'h0008);
    tick(); Done = 1'b1;
    tick(); Done = 1'b0;
    chk("t1_pc", 32'(PC), 1);
    chk("t1_icnt", 32'(InstrCount), 1);
    tick(); tick();
    chk("t1_halted_busy", 32'(Busy), 0);
    chk("t1_halted_pc", 32'(PC), 1);
    chk("t1_runs", 32'(run_cnt - base), 1);
    chk("t1_tmo", 32'(Timeout), 0);

    // mvi with immediate
    rom[0] = 16'h0042; rom[1] = 16'h00A5; rom[2] = 16'h01C0; base = run_cnt;
    Start = 1'b1; tick(); Start = 1'b0;
    chk("t2_icnt_cleared", 32'(InstrCount), 0);
    chk("t2_pc_cleared", 32'(PC), 0);
    tick(); tick();
    chk("t2_issue_run", 32'(Run), 1);
    chk("t2_issue_din", 32'(DIN), 'h0042);
    tick();
    chk("t2_wait1_din", 32'(DIN), 'h00A5);
    rom[1] = 16'hFFFF;
    tick();
    chk("t2_wait2_din", 32'(DIN), 'h00A5);
    tick();
    chk("t2_wait3_din", 32'(DIN), 'h00A5);
    Done = 1'b1;
    tick(); Done = 1'b0;
    chk("t2_pc", 32'(PC), 2);
    chk("t2_icnt", 32'(InstrCount), 1);
    tick(); tick();
    chk("t2_halted_busy", 32'(Busy), 0);
    chk("t2_runs", 32'(run_cnt - base), 1);

    // Watchdog timeout: WAIT entered on the 4th edge, Timeout on the 19th
    rom[0] = 16'h0008; rom[1] = 16'h01C0;
    Start = 1'b1; tick(); Start = 1'b0;
    tick(); tick(); tick();
    repeat (14) tick();
    chk("t3_no_tmo_yet", 32'(Timeout), 0);
    chk("t3_busy_before_tmo", 32'(Busy), 1);
    tick();
    chk("t3_tmo_set", 32'(Timeout), 1);
    chk("t3_tmo_busy", 32'(Busy), 0);
    chk("t3_tmo_run", 32'(Run), 0);

    // Restart clears Timeout; then asynchronous reset during WAIT
    rom[0] = 16'h0008; rom[1] = 16'h0010; rom[2] = 16'h01C0;
    Start = 1'b1; tick(); Start = 1'b0;
    chk("t4_start_clears_tmo", 32'(Timeout), 0);
    tick(); tick(); tick(); Done = 1'b1;
    tick(); Done = 1'b0;
    chk("t4_pc1", 32'(PC), 1);
    chk("t4_icnt1", 32'(InstrCount), 1);
    tick(); tick();
    chk("t4_issue_din", 32'(DIN), 'h0010);
    tick();
    chk("t4_wait_memaddr", 32'(MemAddr), 2);
    #2 Reset = 1'b1;
    #1;
    chk("t4_async_busy", 32'(Busy), 0);
    chk("t4_async_run", 32'(Run), 0);
    chk("t4_async_din", 32'(DIN), 0);
    chk("t4_async_memaddr", 32'(MemAddr), 0);
    chk("t4_async_pc", 32'(PC), 0);
    chk("t4_async_icnt", 32'(InstrCount), 0);
    chk("t4_async_tmo", 32'(Timeout), 0);
    base = run_cnt;
    tick(); Reset = 1'b0; Done = 1'b1;
    tick(); Done = 1'b0;
    tick(); tick();
    chk("t4_done_after_rst_pc", 32'(PC), 0);
    chk("t4_done_after_rst_icnt", 32'(InstrCount), 0);
    chk("t4_done_after_rst_busy", 32'(Busy), 0);
    chk("t4_done_after_rst_runs", 32'(run_cnt - base), 0);

    // Done held high and Start held through busy cycles
    base = run_cnt;
    Start = 1'b1; Done = 1'b1;
    tick();
    chk("t5_fetch_pc", 32'(PC), 0);
    tick(); tick();
    chk("t5_issue_run", 32'(Run), 1);
    chk("t5_issue_pc", 32'(PC), 0);
    tick();
    chk("t5_wait_pc", 32'(PC), 0);
    tick();
    chk("t5_pc1", 32'(PC), 1);
    chk("t5_icnt1", 32'(InstrCount), 1);
    tick(); tick();
    chk("t5_issue2_run", 32'(Run), 1);
    tick();
    chk("t5_wait2_pc", 32'(PC), 1);
    tick();
    chk("t5_pc2", 32'(PC), 2);
    chk("t5_icnt2", 32'(InstrCount), 2);
    tick(); Start = 1'b0;
    tick();
    chk("t5_halted_busy", 32'(Busy), 0);
    chk("t5_halted_pc", 32'(PC), 2);
    chk("t5_runs", 32'(run_cnt - base), 2);
    Done = 1'b0;

    // ADDR_W=2: mvi at address 3 takes its immediate from address 0, PC wraps to 1
    Reset2 = 1'b0; Done2 = 1'b1; Start2 = 1'b1;
    tick(); Start2 = 1'b0;
    repeat (15) tick();
    chk("t6_mvi_pc", 32'(PC2), 3);
    chk("t6_mvi_imm_din", 32'(DIN2), 'h0080);
    chk("t6_wait_run", 32'(Run2), 0);
    tick();
    chk("t6_pc_wrap", 32'(PC2), 1);
    chk("t6_icnt", 32'(InstrCount2), 4);
    chk("t6_runs", 32'(run2_cnt), 4);
    chk("t6_no_x", 32'($isunknown({MemAddr2, DIN2, Run2, Busy2, PC2, InstrCount2, Timeout2})), 0);
    Reset2 = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
